multicycle_control_fsm: RTL

Moore/Mealy sequencer for the multicycle MIPS datapath: a state machine that walks each instruction through fetch, decode, execute, memory and write-back, with one state per cycle. It drives every mux select and write enable of the shared memory/ALU/register-file datapath, replacing the single-cycle combinational control decoder. Memory accesses use a `mem_ready` handshake so the datapath can stall on slow memory.

---
 rtl/multicycle_control_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for the multicycle MIPS datapath. One state per cycle
//   walks each instruction through fetch / decode / execute / memory /
//   write-back. It drives every mux select and write enable of the shared
//   datapath. Memory accesses in FETCH, MEMRD and MEMWR stall on mem_ready.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   opcode            : IR[31:26], looked at only in DECODE and MEMADR
//   mem_ready         : memory finishes the current access this cycle
//   PCWrite..PCSource : datapath controls (combinational from state)
//   illegal_op        : one-cycle pulse in DECODE on an unknown opcode
//   state             : current state code, for debug
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_e;

  state_e state_q, state_d;
  state_e dec_s;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    // During reset the selects show FETCH values whatever state_q holds;
    // the enables are masked below.
    dec_s      = rst ? FETCH : state_q;
    state_d    = FETCH;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    illegal_op = 1'b0;
    case (dec_s)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC only load when the fetch actually completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        Branch   = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;  // codes 12-15: everything low
    endcase
    // Reset aborts with no write enable asserted in that cycle.
    if (rst) begin
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
